// File: rtl/rtob_write_arbiter.sv
// Round-robin write arbiter and flush sequencer in front of one RTOB core write port.
// Several valid/ready requesters share the core's single write interface. Entries
// whose timestamp goes backwards are dropped and reported. A flush request drives
// rtob_flush for a fixed time, then waits a recovery period before traffic resumes.
module rtob_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FLUSH_CYCLES   = 8,
  parameter int RECOVER_CYCLES = 4,
  parameter int ID_W           = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   rtob_write,
  output logic [127:0]           rtob_din,
  output logic                   rtob_flush,
  input  logic                   rtob_full,
  output logic [ID_W-1:0]        grant_id,
  output logic                   order_error,
  output logic [127:0]           order_error_data,
  output logic [31:0]            drop_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [7:0] FLUSH_LAST   = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_CYCLES - 1);

  state_t            state_r, state_next_s;
  logic [7:0]        cnt_r, cnt_next_s;
  logic              flush_start_s;

  logic [ID_W-1:0]   rr_ptr_r;
  logic              have_last_r;
  logic [63:0]       last_ts_r;

  logic              found_hi_s, found_lo_s, found_s;
  logic [ID_W-1:0]   sel_hi_s, sel_lo_s, sel_s;
  logic [127:0]      slice_s;
  logic [63:0]       ts_s;
  logic              accept_ok_s, xfer_s, in_order_s;

  logic              rtob_write_r, rtob_flush_r, flush_busy_r, order_error_r;
  logic [127:0]      rtob_din_r, order_error_data_r;
  logic [ID_W-1:0]   grant_id_r;
  logic [31:0]       drop_count_r;

  // Flush sequencer next state; a flush request in any busy state restarts the flush count.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    flush_start_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (flush_req) begin
          state_next_s  = ST_FLUSH;
          cnt_next_s    = FLUSH_LAST;
          flush_start_s = 1'b1;
        end else begin
          state_next_s  = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          cnt_next_s    = FLUSH_LAST;
          flush_start_s = 1'b1;
        end else if (cnt_r == 8'd0) begin
          if (RECOVER_CYCLES == 0) begin
            state_next_s = ST_RUN;
            cnt_next_s   = 8'd0;
          end else begin
            state_next_s = ST_RECOVER;
            cnt_next_s   = RECOVER_LAST;
          end
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (flush_req) begin
          state_next_s  = ST_FLUSH;
          cnt_next_s    = FLUSH_LAST;
          flush_start_s = 1'b1;
        end else if (cnt_r == 8'd0) begin
          state_next_s = ST_RUN;
          cnt_next_s   = 8'd0;
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      default: begin
        state_next_s = ST_RUN;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // Flush sequencer state and cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_RUN;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Round-robin pick: first valid above rr_ptr wins, otherwise the first valid at or below it.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    sel_hi_s   = '0;
    sel_lo_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi_s && req_valid[i] && (i > int'(rr_ptr_r))) begin
        found_hi_s = 1'b1;
        sel_hi_s   = ID_W'(i);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (!found_lo_s && req_valid[i] && (i <= int'(rr_ptr_r))) begin
        found_lo_s = 1'b1;
        sel_lo_s   = ID_W'(i);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
    found_s = found_hi_s | found_lo_s;
    sel_s   = found_hi_s ? sel_hi_s : sel_lo_s;
  end

  // Ready is granted only to the selected requester and only when a write can be taken now.
  always_comb begin
    accept_ok_s = (state_r == ST_RUN) && !rtob_full && !flush_req;
    xfer_s      = found_s && accept_ok_s;
    req_ready   = '0;
    slice_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_s == ID_W'(i)) begin
        req_ready[i] = xfer_s;
        slice_s      = req_data[128*i +: 128];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
    ts_s       = slice_s[127:64];
    in_order_s = !have_last_r || (ts_s >= last_ts_r);
  end

  // Arbitration pointer, ordering history and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_r           <= ID_W'(NUM_REQ - 1);
      have_last_r        <= 1'b0;
      last_ts_r          <= 64'd0;
      rtob_write_r       <= 1'b0;
      rtob_din_r         <= 128'd0;
      rtob_flush_r       <= 1'b0;
      flush_busy_r       <= 1'b0;
      grant_id_r         <= '0;
      order_error_r      <= 1'b0;
      order_error_data_r <= 128'd0;
      drop_count_r       <= 32'd0;
    end else begin
      rtob_flush_r  <= (state_next_s == ST_FLUSH);
      flush_busy_r  <= (state_next_s != ST_RUN);
      rtob_write_r  <= xfer_s && in_order_s;
      order_error_r <= xfer_s && !in_order_s;
      if (xfer_s) begin
        rr_ptr_r   <= sel_s;
        grant_id_r <= sel_s;
      end else begin
        rr_ptr_r   <= rr_ptr_r;
        grant_id_r <= grant_id_r;
      end
      if (flush_start_s) begin
        have_last_r <= 1'b0;
        last_ts_r   <= 64'd0;
      end else if (xfer_s && in_order_s) begin
        have_last_r <= 1'b1;
        last_ts_r   <= ts_s;
        rtob_din_r  <= slice_s;
      end else if (xfer_s) begin
        order_error_data_r <= slice_s;
        if (drop_count_r != 32'hFFFF_FFFF) begin
          drop_count_r <= drop_count_r + 32'd1;
        end else begin
          drop_count_r <= drop_count_r;
        end
      end else begin
        have_last_r <= have_last_r;
      end
    end
  end

  assign rtob_write       = rtob_write_r;
  assign rtob_din         = rtob_din_r;
  assign rtob_flush       = rtob_flush_r;
  assign flush_busy       = flush_busy_r;
  assign grant_id         = grant_id_r;
  assign order_error      = order_error_r;
  assign order_error_data = order_error_data_r;
  assign drop_count       = drop_count_r;

endmodule
